// File: rtl/systolic_sram_ctrl.sv
// SRAM sequencer for a PE_ROW x PE_ROW weight-stationary systolic tile.
// Define SYSTOLIC_ACCUM_EN to stream the existing output tile back as partial sums.
module systolic_sram_ctrl #(
    parameter int PE_ROW     = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int DRAIN_LAT  = 2*PE_ROW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] wgt_base,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [ADDR_WIDTH-1:0] out_base,
    input  logic [ADDR_WIDTH-1:0] num_rows,
    input  logic                  acc_mode,
    output logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  write,
    output logic                  load_weight,
    output logic                  save,
    output logic                  first_partial,
    output logic [PE_ROW-1:0]     enable,
    output logic                  busy,
    output logic                  done
);

    localparam int LIM_A = (PE_ROW > DRAIN_LAT) ? PE_ROW : DRAIN_LAT;
    localparam int LIM   = (LIM_A > (1 << ADDR_WIDTH)) ? LIM_A : (1 << ADDR_WIDTH);
    localparam int CW    = $clog2(LIM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_GAP,
        S_STREAM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         lim;
    logic                  last;
    logic [ADDR_WIDTH-1:0] cnt_a;
    logic [ADDR_WIDTH-1:0] wgt_q;
    logic [ADDR_WIDTH-1:0] in_q;
    logic [ADDR_WIDTH-1:0] out_q;
    logic [ADDR_WIDTH-1:0] m_q;
    logic [PE_ROW-1:0]     enable_q;
    logic                  act_cur;
    logic                  act_nxt;
    logic                  accept;

`ifdef SYSTOLIC_ACCUM_EN
    logic                  acc_q;
`else
    logic                  unused_acc;
    assign unused_acc = acc_mode;
`endif

    assign accept = (state == S_IDLE) && start && !abort;
    assign cnt_a  = ADDR_WIDTH'(cnt);
    assign last   = (cnt == lim);

    always_comb begin
        lim = '0;
        unique case (state)
            S_LOAD_W:          lim = CW'(PE_ROW);
            S_DRAIN:           lim = CW'(DRAIN_LAT - 1);
            S_STREAM, S_WRITE: lim = CW'(m_q) - CW'(1);
            default:           lim = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (accept) state_n = (num_rows == '0) ? S_DONE : S_LOAD_W;
            S_LOAD_W: if (last) state_n = S_GAP;
            S_GAP:    state_n = S_STREAM;
            S_STREAM: if (last) state_n = (DRAIN_LAT == 0) ? S_WRITE : S_DRAIN;
            S_DRAIN:  if (last) state_n = S_WRITE;
            S_WRITE:  if (last) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
    end

    // The enable wavefront only ripples while the array is computing.
    assign act_cur = (state == S_STREAM) || (state == S_DRAIN) || (state == S_WRITE);
    assign act_nxt = (state_n == S_STREAM) || (state_n == S_DRAIN) || (state_n == S_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wgt_q    <= '0;
            in_q     <= '0;
            out_q    <= '0;
            m_q      <= '0;
            enable_q <= '0;
`ifdef SYSTOLIC_ACCUM_EN
            acc_q    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state_n != state || state == S_IDLE) cnt <= '0;
            else cnt <= cnt + CW'(1);
            if (accept) begin
                wgt_q <= wgt_base;
                in_q  <= in_base;
                out_q <= out_base;
                m_q   <= num_rows;
`ifdef SYSTOLIC_ACCUM_EN
                acc_q <= acc_mode;
`endif
            end
            if (act_cur && act_nxt) enable_q <= (enable_q << 1) | PE_ROW'(1);
            else enable_q <= '0;
        end
    end

    always_comb begin
        raddr_a       = '0;
        raddr_b       = '0;
        waddr         = '0;
        write         = 1'b0;
        load_weight   = 1'b0;
        save          = 1'b0;
        first_partial = 1'b1;
        done          = 1'b0;
        unique case (state)
            S_LOAD_W: begin
                load_weight = 1'b1;
                save        = last;
                raddr_a     = last ? wgt_q + ADDR_WIDTH'(PE_ROW - 1) : wgt_q + cnt_a;
            end
            S_GAP: raddr_a = wgt_q + ADDR_WIDTH'(PE_ROW - 1);
            S_STREAM: begin
                raddr_a = in_q + cnt_a;
`ifdef SYSTOLIC_ACCUM_EN
                raddr_b       = out_q + cnt_a;
                first_partial = ~acc_q;
`endif
            end
            S_DRAIN: raddr_a = in_q + m_q - ADDR_WIDTH'(1);
            S_WRITE: begin
                raddr_a = in_q + m_q - ADDR_WIDTH'(1);
                write   = 1'b1;
                waddr   = out_q + cnt_a;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign enable = enable_q;
    assign busy   = (state != S_IDLE);

endmodule

// File: doc/systolic_sram_ctrl.md
SYSTOLIC_SRAM_CTRL -- requirements
Module: systolic_sram_ctrl

Interface
REQ-001 SHALL have parameter PE_ROW, default 16: systolic array dimension and enable vector width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7: SRAM address width.
REQ-003 SHALL have parameter DRAIN_LAT, default 2*PE_ROW: number of cycles between the last input read and the first result write.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle job request.
REQ-007 SHALL have port abort, input, 1 bit: synchronous job cancel.
REQ-008 SHALL have ports wgt_base, in_base and out_base, each input, ADDR_WIDTH bits: base addresses of the weight, input and output tiles.
REQ-009 SHALL have port num_rows, input, ADDR_WIDTH bits: M, the number of input vectors to stream.
REQ-010 SHALL have port acc_mode, input, 1 bit: 1 = add the existing output tile as partial sum.
REQ-011 SHALL have port raddr_a, output, ADDR_WIDTH bits: weight/input read address.
REQ-012 SHALL have port raddr_b, output, ADDR_WIDTH bits: partial-sum read address.
REQ-013 SHALL have ports waddr, output, ADDR_WIDTH bits, and write, output, 1 bit: result write address and strobe.
REQ-014 SHALL have ports load_weight, save and first_partial, each output, 1 bit: systolic control strobes.
REQ-015 SHALL have port enable, output, PE_ROW bits: skewed PE row enable.
REQ-016 SHALL have ports busy and done, each output, 1 bit: busy = job active; done = one-cycle completion pulse.

Function
REQ-017 SHALL implement the FSM IDLE -> LOAD_W -> GAP -> STREAM -> DRAIN -> WRITE -> DONE -> IDLE.
REQ-018 SHALL sample start only in IDLE; start in any other state SHALL be ignored.
REQ-019 SHALL latch wgt_base, in_base, out_base, num_rows and acc_mode on acceptance and hold them for the whole job.
REQ-020 If start is sampled at edge t, LOAD_W SHALL occupy cycles t+1..t+PE_ROW+1 with load_weight=1 and raddr_a=wgt_base+k for k=0..PE_ROW-1, raddr_a held on the final cycle, and save=1 on the final cycle only.
REQ-021 GAP SHALL last exactly 1 cycle with all strobes low.
REQ-022 STREAM SHALL last M cycles with raddr_a=in_base+k, k=0..M-1.
REQ-023 enable SHALL be all-zero on STREAM entry and, every cycle of STREAM, DRAIN and WRITE, shift left by one with 1 inserted at bit 0, saturating at all-ones.
REQ-024 DRAIN SHALL last DRAIN_LAT cycles with raddr_a held at its last value.
REQ-025 WRITE SHALL last M cycles with write=1 and waddr=out_base+k, k=0..M-1.
REQ-026 DONE SHALL last 1 cycle with done=1 and enable cleared; done SHALL be asserted at cycle t+PE_ROW+3+2M+DRAIN_LAT.
REQ-027 All address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 If num_rows=0 at acceptance, the controller SHALL go IDLE -> DONE directly, with no SRAM access and no strobes.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with all outputs at reset values and no done pulse.
REQ-031 Simultaneous start and abort in IDLE: abort SHALL win and start SHALL be ignored.

Reset
REQ-032 While rst=1 at a rising edge, the FSM SHALL enter IDLE and all outputs SHALL be 0 except first_partial=1; reset mid-job SHALL abort the job without a done pulse.

Configuration
REQ-033 Macro SYSTOLIC_ACCUM_EN defined: during STREAM, raddr_b SHALL equal out_base+k and first_partial SHALL equal ~acc_mode latched.
REQ-034 Macro SYSTOLIC_ACCUM_EN undefined: acc_mode SHALL be ignored, first_partial SHALL be constant 1 and raddr_b constant 0.

Verification (PE_ROW=16, ADDR_WIDTH=7, DRAIN_LAT=32)
REQ-035 start at t, wgt_base=32, in_base=0, out_base=64, M=16 -> raddr_a 32..47 at t+1..t+16, save at t+17, write with waddr 64..79 at t+67..t+82, done at t+83.
REQ-036 Second start asserted during STREAM -> ignored; exactly one done pulse; busy continuous.
REQ-037 in_base=120, M=16 -> raddr_a sequence 120..127 then 0..7.
REQ-038 abort in DRAIN -> next cycle all outputs 0, busy=0, no done; a fresh start is accepted immediately.
REQ-039 M=0 -> done one cycle after acceptance; write, load_weight and save never asserted.
REQ-040 SYSTOLIC_ACCUM_EN defined, acc_mode=1 -> first_partial=0 and raddr_b 64..79 during STREAM; acc_mode=0 -> first_partial=1.
